// File: rtl/caesar_stream_cipher.sv
// ============================================================================
// Module      : caesar_stream_cipher
// Description : Streaming Caesar/Vigenere letter cipher with one-deep output
//               register, programmable key slots and letter counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module caesar_stream_cipher #(
    parameter int KEY_DEPTH = 8,
    parameter int KI_W      = $clog2(KEY_DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            key_we,
    input  logic [KI_W-1:0] key_addr,
    input  logic [4:0]      key_data,
    input  logic [KI_W:0]   key_len,
    input  logic            vig,
    input  logic            dec,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [7:0]      in_data,
    input  logic            in_last,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [7:0]      out_data,
    output logic            out_last,
    output logic [15:0]     letter_cnt
);

    localparam logic [KI_W:0] C_DEPTH = (KI_W+1)'(KEY_DEPTH);
    localparam logic [KI_W:0] C_ONE   = (KI_W+1)'(1);

    logic [4:0]      r_key [KEY_DEPTH];
    logic [KI_W-1:0] r_kp;
    logic            r_out_valid;
    logic [7:0]      r_out_data;
    logic            r_out_last;
    logic [15:0]     r_cnt;

    logic            w_xfer;
    logic            w_upper;
    logic            w_lower;
    logic            w_letter;
    logic [7:0]      w_base;
    logic [4:0]      w_slot;
    logic [4:0]      w_k;
    logic [7:0]      w_off_full;
    logic [5:0]      w_off;
    logic [5:0]      w_sum;
    logic [5:0]      w_mod;
    logic [7:0]      w_char;
    logic [KI_W:0]   w_len;
    logic            w_wrap;
    logic [KI_W-1:0] w_kp_next;

    assign in_ready = !r_out_valid || out_ready;
    assign w_xfer   = in_valid && in_ready;

    assign w_upper  = (in_data >= 8'd65) && (in_data <= 8'd90);
    assign w_lower  = (in_data >= 8'd97) && (in_data <= 8'd122);
    assign w_letter = w_upper || w_lower;
    assign w_base   = w_upper ? 8'd65 : 8'd97;

    // Stored shifts 26..31 alias onto 0..5.
    assign w_slot   = vig ? r_key[r_kp] : r_key[0];
    assign w_k      = (w_slot >= 5'd26) ? (w_slot - 5'd26) : w_slot;

    assign w_off_full = in_data - w_base;
    assign w_off      = w_off_full[5:0];
    assign w_sum      = dec ? (w_off + 6'd26 - {1'b0, w_k}) : (w_off + {1'b0, w_k});
    assign w_mod      = (w_sum >= 6'd26) ? (w_sum - 6'd26) : w_sum;
    assign w_char     = w_letter ? (w_base + {2'b00, w_mod}) : in_data;

    assign w_len     = (key_len == '0)     ? C_ONE   :
                       (key_len > C_DEPTH) ? C_DEPTH : key_len;
    assign w_wrap    = ({1'b0, r_kp} == (w_len - C_ONE));
    assign w_kp_next = w_wrap ? '0 : (r_kp + KI_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < KEY_DEPTH; i++) begin
                r_key[i] <= '0;
            end
        end else if (key_we) begin
            r_key[key_addr] <= key_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_kp        <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= 8'h00;
            r_out_last  <= 1'b0;
            r_cnt       <= 16'h0000;
        end else begin
            if (w_xfer) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_char;
                r_out_last  <= in_last;
                // Caesar mode and end-of-message both park the pointer on slot 0.
                if (in_last || !vig) begin
                    r_kp <= '0;
                end else if (w_letter) begin
                    r_kp <= w_kp_next;
                end
                if (w_letter && (r_cnt != 16'hFFFF)) begin
                    r_cnt <= r_cnt + 16'd1;
                end
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_last   = r_out_last;
    assign letter_cnt = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_caesar_stream_cipher.sv
// ============================================================================
// Module      : tb_caesar_stream_cipher
// Description : Scoreboard bench for caesar_stream_cipher with reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_caesar_stream_cipher;

    localparam int KD = 8;
    localparam int KW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          key_we;
    logic [KW-1:0] key_addr;
    logic [4:0]    key_data;
    logic [KW:0]   key_len;
    logic          vig;
    logic          dec;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    in_data;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [7:0]    out_data;
    logic          out_last;
    logic [15:0]   letter_cnt;

    caesar_stream_cipher #(.KEY_DEPTH(KD)) dut (
        .clk        (clk),
        .rst        (rst),
        .key_we     (key_we),
        .key_addr   (key_addr),
        .key_data   (key_data),
        .key_len    (key_len),
        .vig        (vig),
        .dec        (dec),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .letter_cnt (letter_cnt)
    );

    initial forever #5 clk = ~clk;

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [8:0] sb_q[$];
    int         mkey[KD];
    int         mkp;
    int         mcnt;
    bit         stall   = 1'b0;
    bit         bp_rand = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    function automatic bit is_letter(input logic [7:0] c);
        return (c >= 8'd65 && c <= 8'd90) || (c >= 8'd97 && c <= 8'd122);
    endfunction

    // Reference cipher straight from the alphabet arithmetic.
    function automatic logic [7:0] ref_char(input logic [7:0] c, input int k, input bit d);
        int base;
        int sh;
        if (c >= 8'd65 && c <= 8'd90)       base = 65;
        else if (c >= 8'd97 && c <= 8'd122) base = 97;
        else return c;
        sh = k % 26;
        if (d) sh = 26 - sh;
        return 8'(base + ((int'(c) - base + sh) % 26));
    endfunction

    function automatic int eff_len();
        int l;
        l = int'(key_len);
        if (l == 0) l = 1;
        if (l > KD) l = KD;
        return l;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < KD; i++) mkey[i] = 0;
        mkp  = 0;
        mcnt = 0;
        sb_q.delete();
    endtask

    task automatic model_xfer(input logic [7:0] c, input bit last);
        int k;
        k = vig ? mkey[mkp] : mkey[0];
        sb_q.push_back({ref_char(c, k, dec), last});
        if (is_letter(c)) begin
            if (mcnt < 65535) mcnt++;
            if (vig) mkp = (mkp == eff_len() - 1) ? 0 : (mkp + 1) % KD;
        end
        if (!vig || last) mkp = 0;
    endtask

    // Monitor: pops the scoreboard on every output handshake.
    initial forever begin
        @(negedge clk);
        if (!rst && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_output", int'(out_data), -1);
            end else begin
                logic [8:0] e;
                e = sb_q.pop_front();
                chk("out_data", int'(out_data), int'(e[8:1]));
                chk("out_last", int'(out_last), int'(e[0]));
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #2;
        out_ready = stall ? 1'b0 : (bp_rand ? ($urandom_range(0, 3) != 0) : 1'b1);
    end

    task automatic wr_key(input int a, input int d);
        key_we   = 1'b1;
        key_addr = KW'(a);
        key_data = 5'(d);
        @(posedge clk);
        #1;
        key_we   = 1'b0;
        mkey[a]  = d;
    endtask

    task automatic send(input logic [7:0] c, input bit last = 1'b0,
                        input bit we = 1'b0, input int wa = 0, input int wd = 0);
        bit ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_data  = c;
        in_last  = last;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            chk("in_ready_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        if (we) begin
            key_we   = 1'b1;
            key_addr = KW'(wa);
            key_data = 5'(wd);
        end
        model_xfer(c, last);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        key_we   = 1'b0;
        if (we) mkey[wa] = wd;
    endtask

    task automatic drain();
        for (int i = 0; i < 500; i++) begin
            if (sb_q.size() == 0) break;
            @(negedge clk);
        end
        chk("drain", sb_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic send_str(input string s, input int last_idx = -1);
        for (int i = 0; i < s.len(); i++) send(s[i], i == last_idx);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; key_we = 1'b0; key_addr = '0; key_data = '0; key_len = 4'd0;
        vig = 1'b0; dec = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;
        out_ready = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_out_last", int'(out_last), 0);
        chk("rst_letter_cnt", int'(letter_cnt), 0);
        chk("rst_in_ready", int'(in_ready), 1);

        // Caesar encrypt / decrypt, including aliased key value 29.
        wr_key(0, 3);
        send_str("aZ!");
        drain();
        chk("caesar_cnt", int'(letter_cnt), 2);
        dec = 1'b1;
        send_str("Ac");
        wr_key(0, 29);
        send_str("Ac");
        drain();
        chk("caesar_dec_cnt", int'(letter_cnt), mcnt);

        // Vigenere with end-of-message pointer reset.
        dec = 1'b0; vig = 1'b1; key_len = 4'd3;
        wr_key(0, 10); wr_key(1, 4); wr_key(2, 24);
        send_str("AB C", 3);
        send("A");
        drain();

        // key_len boundaries: 0 acts as 1, above depth acts as depth.
        key_len = 4'd0;
        send_str("AAA");
        key_len = 4'd15;
        for (int i = 3; i < KD; i++) wr_key(i, i + 1);
        send_str("abcdefghij", 9);
        drain();

        // Backpressure: held output must not change and input must stall.
        stall = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        send("m");
        in_valid = 1'b1; in_data = "n"; in_last = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_in_ready", int'(in_ready), 0);
            chk("bp_out_data_hold", int'(out_data), int'(sb_q[0][8:1]));
        end
        stall = 1'b0;
        send("n");
        send("o");
        drain();
        chk("bp_cnt", int'(letter_cnt), mcnt);

        // Key write coinciding with a transfer uses the old slot value.
        vig = 1'b0; dec = 1'b0;
        wr_key(0, 3);
        send("a", 1'b0, 1'b1, 0, 5);
        send("a");
        drain();

        // Reset mid-message with a character held in the output register.
        vig = 1'b1; key_len = 4'd3;
        wr_key(0, 10); wr_key(1, 4); wr_key(2, 24);
        send("A");
        send("B");
        stall = 1'b1;
        repeat (2) @(negedge clk);
        chk("pre_rst_out_valid", int'(out_valid), 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        chk("mid_rst_out_valid", int'(out_valid), 0);
        chk("mid_rst_cnt", int'(letter_cnt), 0);
        chk("mid_rst_in_ready", int'(in_ready), 1);
        stall = 1'b0;
        send("Q");
        drain();

        // Randomised segments with random backpressure and key updates.
        bp_rand = 1'b1;
        for (int seg = 0; seg < 10; seg++) begin
            vig     = 1'($urandom_range(0, 1));
            dec     = 1'($urandom_range(0, 1));
            key_len = 4'($urandom_range(0, 12));
            for (int i = 0; i < 3; i++) wr_key($urandom_range(0, KD - 1), $urandom_range(0, 31));
            for (int i = 0; i < 30; i++) begin
                send(8'($urandom_range(32, 126)), $urandom_range(0, 7) == 0,
                     $urandom_range(0, 5) == 0, $urandom_range(0, KD - 1), $urandom_range(0, 31));
            end
            drain();
            chk("rand_cnt", int'(letter_cnt), mcnt);
        end
        bp_rand = 1'b0;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/caesar_stream_cipher.md
CAESAR_STREAM_CIPHER -- requirements
Module: caesar_stream_cipher

Interface
REQ-001 SHALL have parameter KEY_DEPTH, default 8, number of key-shift slots (power of two, 2..64).
REQ-002 SHALL have parameter KI_W, default $clog2(KEY_DEPTH), key slot index width.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port key_we  input  1  write key_data into slot key_addr.
REQ-006 SHALL have port key_addr  input  KI_W  key slot written.
REQ-007 SHALL have port key_data  input  5  shift value for the slot.
REQ-008 SHALL have port key_len  input  KI_W+1  active slots in Vigenère mode.
REQ-009 SHALL have port vig  input  1  0 = Caesar (slot 0 only), 1 = Vigenère (cycle slots).
REQ-010 SHALL have port dec  input  1  0 = encrypt, 1 = decrypt.
REQ-011 SHALL have ports in_valid input 1, in_ready output 1, in_data input 8 (ASCII), in_last input 1 (end of message).
REQ-012 SHALL have ports out_valid output 1, out_ready input 1, out_data output 8 (ASCII), out_last output 1.
REQ-013 SHALL have port letter_cnt  output 16  count of letters transformed since reset.

Function
REQ-014 Input transfer SHALL occur when in_valid && in_ready; output transfer when out_valid && out_ready.
REQ-015 Single output register; in_ready SHALL equal !out_valid || out_ready (combinational, no bubble under continuous flow).
REQ-016 Latency SHALL be 1 cycle: a character accepted at edge N is presented on out_data from edge N with out_valid=1.
REQ-017 out_data, out_last SHALL stay stable while out_valid && !out_ready.
REQ-018 Letter classification: 'A'..'Z' (65..90) base 65; 'a'..'z' (97..122) base 97; case SHALL be preserved.
REQ-019 Non-letters SHALL pass unchanged, SHALL NOT advance the key pointer, SHALL NOT increment letter_cnt.
REQ-020 Effective shift K = key_data value mod 26 (stored values 26..31 act as 0..5).
REQ-021 Encrypt: out = base + ((c-base)+K) mod 26; decrypt: out = base + ((c-base)-K+26) mod 26.
REQ-022 Caesar mode SHALL always use slot 0; key pointer held at 0.
REQ-023 Vigenère mode SHALL use slot at key pointer kp; kp advances by 1 per accepted letter, wraps to 0 after kp == key_len-1.
REQ-024 key_len of 0 or greater than KEY_DEPTH SHALL be treated as KEY_DEPTH... except 0 SHALL be treated as 1.
REQ-025 Clarification of REQ-024: key_len 0 -> 1; key_len > KEY_DEPTH -> KEY_DEPTH.
REQ-026 Accepting a character with in_last=1 SHALL reset kp to 0 after that character; out_last SHALL mirror it.
REQ-027 key_we in the same cycle as an input transfer: the accepted character SHALL use the pre-write slot value; write visible from next transfer.
REQ-028 Changing vig, dec or key_len SHALL affect only characters accepted after the change; kp is not reset by the change.
REQ-029 letter_cnt SHALL saturate at 16'hFFFF.

Reset
REQ-030 On rst at a rising edge: out_valid=0, out_data=8'h00, out_last=0, kp=0, letter_cnt=0, all key slots=0.
REQ-031 rst SHALL take priority over simultaneous key_we and input transfer; in_ready SHALL read 1 the cycle after reset.
REQ-032 A character held in the output register at reset SHALL be discarded.

Verification
REQ-033 Caesar, slot0=3, enc: 'a','Z','!' -> 'd','C','!'; letter_cnt=2.
REQ-034 Caesar, slot0=3, dec: 'A','c' -> 'X','z'; slot0=29 gives identical result.
REQ-035 Vigenère, slots 10,4,24, key_len=3, enc "AB C" with in_last on 'C' -> "KF A", out_last on 'A'; next 'A' -> 'K' (kp reset).
REQ-036 Backpressure: out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0, out_data constant, no character lost or duplicated after release.
REQ-037 Reset mid-message in Vigenère (kp=2, out_valid=1) -> next cycle out_valid=0, letter_cnt=0, first new letter uses slot 0 (value 0, output equals input).
REQ-038 key_we to slot 0 (3->5) in same cycle as accepting 'a' -> output 'd'; following 'a' -> 'f'.
